// File: rtl/regfile_arbiter.sv
// regfile_arbiter: owns the single port of the 16x16 register memory, sharing it between the CPU
// datapath and the LCD scanner and running the CLEAR sweep. REGARB_FIXED_PRIO_EN selects fixed CPU priority.
module regfile_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: a requester raises req and holds it (with stable address/data) until it sees
    // its gnt pulse; it drops req within that gnt cycle, so a req still high at the next edge
    // is a new request. gnt and mem_* are registered and appear in the cycle after the
    // sampling edge; a read's rvalid/rdata appear one cycle after its gnt.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    logic [ADDR_W:0]     r_clr_idx;
    logic                r_cpu_gnt;
    logic                r_disp_gnt;
    logic                r_cpu_rd_tag;
    logic                r_disp_rd_tag;
    logic                r_cpu_rvalid;
    logic                r_disp_rvalid;
    logic [DATA_W-1:0]   r_cpu_hold;
    logic [DATA_W-1:0]   r_disp_hold;
    logic                r_clear_busy;
    logic                r_clear_done;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_sweep_end;
    logic                w_arb_open;
    logic                w_pick_cpu;
    logic                w_pick_disp;
    logic                w_issue_cpu;
    logic                w_issue_disp;

    // The cycle that raises clear_done may already carry a grant; clear_req is ignored then.
    always_comb begin
        w_sweep_end = (r_state == ST_CLEAR) && (r_clr_idx == LP_DEPTH);
        w_arb_open  = (r_state == ST_CLEAR) ? w_sweep_end : ~clear_req;
    end

`ifdef REGARB_FIXED_PRIO_EN
    always_comb begin
        w_pick_cpu  = cpu_req;
        w_pick_disp = disp_req & ~cpu_req;
    end
`else
    logic r_last;  // most recent grant: 0 = cpu, 1 = disp

    always_comb begin
        w_pick_cpu  = cpu_req  & (~disp_req | r_last);
        w_pick_disp = disp_req & (~cpu_req  | ~r_last);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (w_issue_cpu || w_issue_disp) begin
            r_last <= w_issue_disp;
        end
    end
`endif

    always_comb begin
        w_issue_cpu  = w_arb_open & w_pick_cpu;
        w_issue_disp = w_arb_open & w_pick_disp;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_clr_idx     <= '0;
            r_cpu_gnt     <= 1'b0;
            r_disp_gnt    <= 1'b0;
            r_cpu_rd_tag  <= 1'b0;
            r_disp_rd_tag <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_disp_rvalid <= 1'b0;
            r_cpu_hold    <= '0;
            r_disp_hold   <= '0;
            r_clear_busy  <= 1'b0;
            r_clear_done  <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_cpu_gnt     <= w_issue_cpu;
            r_disp_gnt    <= w_issue_disp;
            r_clear_done  <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;

            // Owner tag rides one cycle behind the issue, matching the memory's read latency.
            r_cpu_rd_tag  <= w_issue_cpu & ~cpu_we;
            r_disp_rd_tag <= w_issue_disp;
            r_cpu_rvalid  <= r_cpu_rd_tag;
            r_disp_rvalid <= r_disp_rd_tag;
            if (r_cpu_rvalid) begin
                r_cpu_hold <= mem_rdata;
            end
            if (r_disp_rvalid) begin
                r_disp_hold <= mem_rdata;
            end

            case (r_state)
                ST_IDLE, ST_SERVE: begin
                    if (clear_req) begin
                        r_state      <= ST_CLEAR;
                        r_clear_busy <= 1'b1;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                        r_clr_idx    <= (ADDR_W+1)'(1);
                    end else if (w_issue_cpu || w_issue_disp) begin
                        r_state <= ST_SERVE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (w_sweep_end) begin
                        r_clear_busy <= 1'b0;
                        r_clear_done <= 1'b1;
                        r_clr_idx    <= '0;
                        r_state      <= (w_issue_cpu || w_issue_disp) ? ST_SERVE : ST_IDLE;
                    end else begin
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_clr_idx[ADDR_W-1:0];
                        r_mem_wdata <= '0;
                        r_clr_idx   <= r_clr_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Issues only happen while no sweep write is scheduled for the same cycle.
            if (w_issue_cpu) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= cpu_we;
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
            end else if (w_issue_disp) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= disp_addr;
                r_mem_wdata <= '0;
            end
        end
    end

    assign cpu_gnt     = r_cpu_gnt;
    assign disp_gnt    = r_disp_gnt;
    assign cpu_rvalid  = r_cpu_rvalid;
    assign disp_rvalid = r_disp_rvalid;
    assign cpu_rdata   = r_cpu_rvalid  ? mem_rdata : r_cpu_hold;
    assign disp_rdata  = r_disp_rvalid ? mem_rdata : r_disp_hold;
    assign clear_busy  = r_clear_busy;
    assign clear_done  = r_clear_done;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Arbiter and sequencer for the single-port 16×16 register memory in the mini CPU. It shares the port between two requesters: the CPU datapath (read/write operands and results) and the LCD display scanner (read-only). It also executes the CLEAR opcode as an internal hardware sweep that zeroes every register. It sits between the CPU state machine / LCD refresh logic and the register storage, and owns the only path to `mem_*`.

## Interface
Parameters:
- ADDR_W, 4, register address width
- DATA_W, 16, register data width
- DEPTH, 16, number of registers cleared by a sweep (≤ 2^ADDR_W)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU register address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  CPU read data
- disp_req  in  1  display read request; held until disp_gnt
- disp_addr  in  ADDR_W  display register address
- disp_gnt  out  1  one-cycle pulse: display request accepted
- disp_rvalid  out  1  one-cycle pulse: disp_rdata valid
- disp_rdata  out  DATA_W  display read data
- clear_req  in  1  start a clear sweep (pulse)
- clear_busy  out  1  sweep in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after mem_en with mem_we=0

## Operation
States:
- IDLE
- SERVE
- CLEAR

Clear sweep:
- Priority order: clear_req > round-robin(cpu, disp).
- clear_req sampled high in IDLE or SERVE → CLEAR. clr_idx starts at 0.
- In CLEAR, each cycle drives mem_en=1, mem_we=1, mem_addr=clr_idx, mem_wdata=0, then increments clr_idx.
- After address DEPTH-1 is written: return to IDLE and pulse clear_done for one cycle.
- clear_busy is high throughout CLEAR.
- No grants are issued during CLEAR. clear_req during CLEAR is ignored.

Round-robin arbitration:
- A 1-bit last-grant pointer `last` tracks the most recent grant. When both requesters are pending, the grant goes to the one not equal to `last`.
- A lone requester is always granted.
- `last` updates on every grant.

Access rules:
- The display path always reads. disp_* accesses never drive mem_we=1.
- The arbiter enters SERVE when a grant is issued and returns to IDLE when no request is pending.
- A read issued while a write to the same address occurred in the previous cycle returns the new data. The memory is write-before-read across cycles.

Read routing:
- An owner tag is registered with each read issue.
- mem_rdata is routed to cpu_rdata or disp_rdata according to the tag.
- The other rdata output holds its last value.

## Timing
Reset (reset=0 at a clock edge):
- All outputs go to 0. State goes to IDLE, clr_idx to 0, and `last`=disp, so the CPU wins the first tie.
- Reset mid-sweep aborts the sweep: clear_done does not pulse, and registers already zeroed stay zeroed.
- Reset also cancels any in-flight rvalid.

Request to response:
- Request sampled at edge T.
- Between edges T and T+1: the granted requester's gnt=1, mem_* are driven for that request, and mem_en=1.
- A read's rdata/rvalid is valid between edges T+1 and T+2, i.e. 2 cycles from request to data.

Throughput:
- One access per cycle. Back-to-back grants are allowed.
- With both requesters continuously pending, grants alternate cpu, disp, cpu, …

Clear sweep timing:
- clear_req sampled at edge T: clear_busy=1 and the first zero-write to addr 0 occur from T.
- The write to DEPTH-1 occurs in cycle T+DEPTH-1.
- clear_done=1 and clear_busy=0 in cycle T+DEPTH.
- Grants resume at the earliest in cycle T+DEPTH.

Simultaneous events:
- clear_req together with cpu_req/disp_req: clear wins. Pending requests stay held and are granted after the sweep.
- A read issued the cycle before a sweep begins still returns its rvalid on schedule.

## Configuration
- REGARB_FIXED_PRIO_EN defined: round-robin is replaced by fixed priority, CPU over display. `last` is not implemented. The display is granted only in cycles with cpu_req=0.
- Undefined (default): round-robin as above.
- Clear-sweep behaviour is identical in both builds.

## Test plan
- Reset, then CPU write addr 3 = 0x00A5; CPU read addr 3 → cpu_gnt 1 cycle after each request, cpu_rvalid with cpu_rdata=0x00A5 2 cycles after the read request.
- cpu_req and disp_req both held for 6 cycles, reads of addr 1/addr 2 → grants cpu, disp, cpu, disp, cpu, disp. Under REGARB_FIXED_PRIO_EN → 6 cpu grants, 0 disp grants.
- Load regs 0..15 with 0x1111; pulse clear_req → clear_busy high for exactly 16 cycles, clear_done 1 pulse, every subsequent read returns 0x0000.
- clear_req asserted in the same cycle as cpu_req (write addr 5 = 0x0007) → sweep runs first. The CPU write is granted in the clear_done cycle, and a subsequent read of addr 5 = 0x0007.
- reset=0 at sweep cycle 8 → no clear_done. Addrs 0..7 read 0x0000, addrs 8..15 keep 0x1111.
- Display read pending alone, CPU write to the same addr in the preceding cycle → disp_rdata returns the newly written value, and cpu_rdata is unchanged.
